// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline register.
package pipe_pkg;

  // Occupancy states; the encoding equals the number of entries held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKIDF = 2'd2
  } pipe_state_t;

  // Default width of the squashable control field at the bottom of the payload.
  localparam int CTRL_W_DEFAULT = 8;

endpackage

// File: rtl/pipe_sat_ctr.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
module pipe_sat_ctr #(
  parameter int STALL_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               inc,
  output logic [STALL_W-1:0] count
);

  logic [STALL_W-1:0] count_q;
  logic [STALL_W-1:0] count_d;

  // Step on inc unless already at the maximum, so the count never wraps to zero.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + STALL_W'(1);
    end
  end

  // Count register; only reset clears it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage.sv
// Elastic pipeline register with valid/ready handshake, optional skid entry,
// synchronous flush that squashes the control field, and a stall counter.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH   = 160,
  parameter int CTRL_W  = CTRL_W_DEFAULT,
  parameter int SKID    = 1,
  parameter int STALL_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         occ,
  output logic [STALL_W-1:0] stall_cnt
);

  pipe_state_t      state_q;
  pipe_state_t      state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             accept;
  logic             issue;
  logic             stall_inc;

  assign out_valid = (state_q != EMPTY);
  assign occ       = state_q;
  assign accept    = in_valid && in_ready;
  assign issue     = out_valid && out_ready;
  assign stall_inc = out_valid && !out_ready;

  // With a skid entry, ready comes straight from state; without it, the single
  // entry can be refilled in the same cycle it drains.
  always_comb begin
    if (SKID != 0) begin
      in_ready = (state_q != SKIDF);
    end else begin
      in_ready = !out_valid || out_ready;
    end
  end

  // A bubble must look like a NOP downstream, so its control bits read as zero.
  always_comb begin
    out_data = main_q;
    if (!out_valid) begin
      out_data[CTRL_W-1:0] = '0;
    end
  end

  // Next state and next entry contents; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d              = EMPTY;
      main_d[CTRL_W-1:0]   = '0;
      skid_d[CTRL_W-1:0]   = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = FULL;
            main_d  = in_data;
          end
        end
        FULL: begin
          if (accept && issue) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = SKIDF;
            skid_d  = in_data;
          end else if (issue) begin
            state_d = EMPTY;
          end
        end
        SKIDF: begin
          if (issue) begin
            state_d = FULL;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and entry registers; reset drops every held entry immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  pipe_sat_ctr #(
    .STALL_W (STALL_W)
  ) u_stall_ctr (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: three instances (skid, no-skid, 3-bit stall counter)
// each tracked by a small queue model, plus directed literal checks.
module tb_pipe_stage;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;

  logic         iv   [3];
  logic [W-1:0] id   [3];
  logic         fl   [3];
  logic         ordy [3];
  logic         irdy [3];
  logic         ov   [3];
  logic [W-1:0] od   [3];
  logic [1:0]   oc   [3];
  logic [15:0]  sc0;
  logic [15:0]  sc1;
  logic [2:0]   sc2;

  int total = 0;
  int bad   = 0;

  int           m_cnt   [3] = '{0, 0, 0};
  logic [W-1:0] m_e0    [3] = '{16'h0, 16'h0, 16'h0};
  logic [W-1:0] m_e1    [3] = '{16'h0, 16'h0, 16'h0};
  int           m_stall [3] = '{0, 0, 0};
  int           m_max   [3] = '{65535, 65535, 7};
  bit           m_skid  [3] = '{1'b1, 1'b0, 1'b1};
  logic         acc;
  logic         iss;

  always #5 clk = ~clk;

  pipe_stage #(.WIDTH(W), .CTRL_W(8), .SKID(1), .STALL_W(16)) u_skid (
    .CLK(clk), .RST(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(id[0]),
    .flush(fl[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .occ(oc[0]), .stall_cnt(sc0)
  );

  pipe_stage #(.WIDTH(W), .CTRL_W(8), .SKID(0), .STALL_W(16)) u_noskid (
    .CLK(clk), .RST(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(id[1]),
    .flush(fl[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .occ(oc[1]), .stall_cnt(sc1)
  );

  pipe_stage #(.WIDTH(W), .CTRL_W(8), .SKID(1), .STALL_W(3)) u_sat (
    .CLK(clk), .RST(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .in_data(id[2]),
    .flush(fl[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
    .occ(oc[2]), .stall_cnt(sc2)
  );

  task automatic checkOutput(input string name, input int k,
                             input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s[%0d] actual=0x%0h required=0x%0h", name, k, act, exp);
    end
  endtask

  task automatic applyStimulus(input int k, input logic v, input logic [W-1:0] d,
                               input logic f, input logic r);
    iv[k]   = v;
    id[k]   = d;
    fl[k]   = f;
    ordy[k] = r;
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] get_stall(input int k);
    case (k)
      0:       return 32'(sc0);
      1:       return 32'(sc1);
      default: return 32'(sc2);
    endcase
  endfunction

  function automatic logic model_in_ready(input int k);
    if (m_skid[k]) return (m_cnt[k] < 2);
    return (m_cnt[k] == 0) || ordy[k];
  endfunction

  // Queue model: issue pops the head, accept appends, flush empties the queue.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int k = 0; k < 3; k++) begin
          m_cnt[k]   = 0;
          m_stall[k] = 0;
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          acc = iv[k] && model_in_ready(k);
          iss = (m_cnt[k] > 0) && ordy[k];
          if ((m_cnt[k] > 0) && !ordy[k] && (m_stall[k] < m_max[k])) m_stall[k]++;
          if (fl[k]) begin
            m_cnt[k] = 0;
          end else begin
            if (iss) begin
              m_e0[k] = m_e1[k];
              m_cnt[k]--;
            end
            if (acc) begin
              if (m_cnt[k] == 0) m_e0[k] = id[k];
              else               m_e1[k] = id[k];
              m_cnt[k]++;
            end
          end
        end
      end
    end
  end

  // Every falling edge, compare all three instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checkOutput("out_valid", k, 32'(ov[k]), 32'(m_cnt[k] > 0));
        checkOutput("occ", k, 32'(oc[k]), 32'(m_cnt[k]));
        checkOutput("in_ready", k, 32'(irdy[k]), 32'(model_in_ready(k)));
        checkOutput("stall_cnt", k, get_stall(k), 32'(m_stall[k]));
        if (m_cnt[k] > 0) checkOutput("out_data", k, 32'(od[k]), 32'(m_e0[k]));
        else              checkOutput("bubble_ctrl", k, 32'(od[k][7:0]), 32'd0);
      end
    end
  end

  // Directed scenarios followed by a randomized run.
  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, '0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput("rst_in_ready", k, 32'(irdy[k]), 32'd1);
      checkOutput("rst_out_valid", k, 32'(ov[k]), 32'd0);
      checkOutput("rst_out_data", k, 32'(od[k]), 32'd0);
      checkOutput("rst_occ", k, 32'(oc[k]), 32'd0);
      checkOutput("rst_stall", k, get_stall(k), 32'd0);
    end

    for (int i = 1; i <= 8; i++) begin
      step;
      applyStimulus(0, 1'b1, W'(i), 1'b0, 1'b1);
      @(negedge clk);
      if (i > 1) begin
        checkOutput("stream_data", 0, 32'(od[0]), 32'(i - 1));
        checkOutput("stream_valid", 0, 32'(ov[0]), 32'd1);
      end
    end
    step;
    applyStimulus(0, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("stream_last", 0, 32'(od[0]), 32'd8);
    checkOutput("stream_stall", 0, 32'(sc0), 32'd0);
    step;

    step;
    applyStimulus(0, 1'b1, 16'hA00A, 1'b0, 1'b0);
    step;
    applyStimulus(0, 1'b1, 16'hB00B, 1'b0, 1'b0);
    step;
    applyStimulus(0, 1'b1, 16'hC00C, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("bp_occ", 0, 32'(oc[0]), 32'd2);
    checkOutput("bp_in_ready", 0, 32'(irdy[0]), 32'd0);
    checkOutput("bp_head", 0, 32'(od[0]), 32'hA00A);
    checkOutput("bp_stall1", 0, 32'(sc0), 32'd1);
    repeat (4) step;
    @(negedge clk);
    checkOutput("bp_stall5", 0, 32'(sc0), 32'd5);
    checkOutput("bp_hold", 0, 32'(od[0]), 32'hA00A);
    step;
    applyStimulus(0, 1'b1, 16'hC00C, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("bp_rel_a", 0, 32'(od[0]), 32'hA00A);
    step;
    @(negedge clk);
    checkOutput("bp_rel_b", 0, 32'(od[0]), 32'hB00B);
    checkOutput("bp_rel_occ", 0, 32'(oc[0]), 32'd1);
    step;
    applyStimulus(0, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("bp_rel_c", 0, 32'(od[0]), 32'hC00C);
    step;
    @(negedge clk);
    checkOutput("bp_stall_final", 0, 32'(sc0), 32'd6);

    step;
    applyStimulus(0, 1'b1, 16'h12FF, 1'b0, 1'b0);
    step;
    applyStimulus(0, 1'b1, 16'h34FF, 1'b0, 1'b0);
    step;
    applyStimulus(0, 1'b1, 16'h56FF, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("fl_pre_occ", 0, 32'(oc[0]), 32'd2);
    step;
    applyStimulus(0, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("fl_valid", 0, 32'(ov[0]), 32'd0);
    checkOutput("fl_ctrl", 0, 32'(od[0][7:0]), 32'd0);
    checkOutput("fl_occ", 0, 32'(oc[0]), 32'd0);
    step;
    applyStimulus(0, 1'b1, 16'h77FF, 1'b0, 1'b0);
    step;
    applyStimulus(0, 1'b1, 16'h88FF, 1'b1, 1'b1);
    step;
    applyStimulus(0, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("fl_acc_valid", 0, 32'(ov[0]), 32'd0);
    step;
    @(negedge clk);
    checkOutput("fl_acc_gone", 0, 32'(ov[0]), 32'd0);

    step;
    applyStimulus(1, 1'b1, 16'h1111, 1'b0, 1'b1);
    step;
    applyStimulus(1, 1'b1, 16'h2222, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("ns_ready_hi", 1, 32'(irdy[1]), 32'd1);
    checkOutput("ns_data1", 1, 32'(od[1]), 32'h1111);
    ordy[1] = 1'b0;
    #1;
    checkOutput("ns_ready_follow_lo", 1, 32'(irdy[1]), 32'd0);
    checkOutput("ns_occ", 1, 32'(oc[1]), 32'd1);
    ordy[1] = 1'b1;
    #1;
    checkOutput("ns_ready_follow_hi", 1, 32'(irdy[1]), 32'd1);
    step;
    applyStimulus(1, 1'b1, 16'h3333, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ns_data2", 1, 32'(od[1]), 32'h2222);
    checkOutput("ns_ready_lo", 1, 32'(irdy[1]), 32'd0);
    step;
    applyStimulus(1, 1'b1, 16'h3333, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("ns_data2_hold", 1, 32'(od[1]), 32'h2222);
    step;
    applyStimulus(1, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("ns_data3", 1, 32'(od[1]), 32'h3333);
    step;

    step;
    applyStimulus(2, 1'b1, 16'h00AB, 1'b0, 1'b0);
    step;
    applyStimulus(2, 1'b0, '0, 1'b0, 1'b0);
    repeat (10) step;
    @(negedge clk);
    checkOutput("sat_hold7", 2, 32'(sc2), 32'd7);
    checkOutput("sat_data", 2, 32'(od[2]), 32'h00AB);
    step;
    applyStimulus(2, 1'b0, '0, 1'b0, 1'b1);
    step;

    step;
    applyStimulus(0, 1'b1, 16'hAAAA, 1'b0, 1'b0);
    applyStimulus(2, 1'b1, 16'hAAAA, 1'b0, 1'b0);
    step;
    applyStimulus(0, 1'b1, 16'hBBBB, 1'b0, 1'b0);
    applyStimulus(2, 1'b1, 16'hBBBB, 1'b0, 1'b0);
    step;
    applyStimulus(0, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(2, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("mid_pre_occ", 0, 32'(oc[0]), 32'd2);
    checkOutput("mid_pre_occ", 2, 32'(oc[2]), 32'd2);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("mid_rst_valid", k, 32'(ov[k]), 32'd0);
      checkOutput("mid_rst_occ", k, 32'(oc[k]), 32'd0);
      checkOutput("mid_rst_in_ready", k, 32'(irdy[k]), 32'd1);
      checkOutput("mid_rst_data", k, 32'(od[k]), 32'd0);
      checkOutput("mid_rst_stall", k, get_stall(k), 32'd0);
    end
    step;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, '0, 1'b0, 1'b1);

    for (int c = 0; c < 3000; c++) begin
      step;
      for (int k = 0; k < 3; k++) begin
        applyStimulus(k, ($urandom_range(3, 0) != 0), W'($urandom),
                      ($urandom_range(15, 0) == 0), ($urandom_range(3, 0) != 0));
      end
    end

    step;
    for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, '0, 1'b0, 1'b1);
    repeat (3) step;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
